// File: rtl/fpu_normalize.sv
// FP32 normalizer/packer: shifts a 48-bit raw significand one bit per cycle until
// bit 46 is the leading one, then packs sign/exp/fraction plus guard/round/sticky.
module fpu_normalize (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [9:0]  in_exp,
    input  logic [47:0] in_mant,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [2:0]  out_grs,
    output logic        out_overflow,
    output logic        out_underflow
);

    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

    state_t             state, state_nx;
    logic               sign_r;
    logic signed [9:0]  exp_r;
    logic [47:0]        mant_r;

    // Resolution of the current NORM cycle: either final (norm_done) or another left shift.
    logic               norm_done;
    logic               fin_zero;
    logic signed [9:0]  fin_exp;
    logic [45:0]        fin_mant;

    always_comb begin
        norm_done = 1'b1;
        fin_zero  = 1'b0;
        fin_exp   = exp_r;
        fin_mant  = mant_r[45:0];
        if (mant_r == 48'd0) begin
            fin_zero = 1'b1;
        end else if (mant_r[47]) begin
            // Right shift keeps the dropped bit alive in the sticky position.
            fin_mant = {mant_r[46:2], mant_r[1] | mant_r[0]};
            fin_exp  = exp_r + 10'sd1;
        end else if (!mant_r[46]) begin
            norm_done = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)  state_nx = NORM;
            NORM:    if (norm_done) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_r <= 1'b0;
            exp_r  <= '0;
            mant_r <= '0;
        end else if (state == IDLE && in_valid) begin
            sign_r <= in_sign;
            exp_r  <= in_exp;
            mant_r <= in_mant;
        end else if (state == NORM && !norm_done) begin
            mant_r <= {mant_r[46:0], 1'b0};
            exp_r  <= exp_r - 10'sd1;
        end
    end

    // Packed result is captured once on entry to DONE and held through backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_word      <= '0;
            out_grs       <= '0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
        end else if (state == NORM && norm_done) begin
            out_grs       <= 3'b000;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            if (fin_zero) begin
                out_word <= {sign_r, 31'b0};
            end else if (fin_exp >= 10'sd255) begin
                out_word     <= {sign_r, 8'hFF, 23'b0};
                out_overflow <= 1'b1;
            end else if (fin_exp <= 10'sd0) begin
                out_word      <= {sign_r, 31'b0};
                out_underflow <= 1'b1;
            end else begin
                out_word <= {sign_r, fin_exp[7:0], fin_mant[45:23]};
                out_grs  <= {fin_mant[22], fin_mant[21], |fin_mant[20:0]};
            end
        end
    end

endmodule
